// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Memory-side responder for the fetch stage's instruction port. A word-
// addressed instruction array is written through a dedicated load port and
// read by fetch requests. Each accepted request travels down a fixed-length
// response pipeline ({v, fault, data} per stage) and emerges exactly LATENCY
// cycles after acceptance. Misaligned or out-of-range fetches return a NOP
// flagged as a fault. A flush squashes everything already in flight.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the array (power of two, 16..65536)
//   LATENCY      cycles from accept to response valid (1..4)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   imem_req_v_i   fetch request valid
//   imem_addr_i    fetch byte address
//   imem_ready_o   request accepted when high together with imem_req_v_i
//   imem_flush_i   squash all in-flight responses
//   imem_data_o    instruction word of the response
//   imem_data_v_o  response valid this cycle
//   imem_fault_o   response belongs to a misaligned / out-of-range fetch
//   load_v_i       array write strobe (has priority over fetches)
//   load_addr_i    array word index to write
//   load_data_i    word to write
// -----------------------------------------------------------------------------
module imem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           imem_req_v_i,
   input  logic [31:0]                    imem_addr_i,
   output logic                           imem_ready_o,
   input  logic                           imem_flush_i,
   output logic [31:0]                    imem_data_o,
   output logic                           imem_data_v_o,
   output logic                           imem_fault_o,
   input  logic                           load_v_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
   input  logic [31:0]                    load_data_i
);

   localparam int          AW  = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Instruction array (not reset)
   logic [31:0] mem_q [DEPTH_WORDS];

   // Response pipeline, index 0 is the stage written at accept
   logic        v_q     [LATENCY];
   logic        fault_q [LATENCY];
   logic [31:0] data_q  [LATENCY];

   logic        accept;
   logic        misaligned;
   logic        out_of_range;
   logic        fault_d;
   logic [31:0] data_d;

   // Loads win the cycle; ready depends on nothing but the load strobe.
   assign imem_ready_o = !load_v_i;
   assign accept       = imem_req_v_i && !load_v_i;

   // Any set bit above the index field places the word beyond the array.
   assign misaligned   = (imem_addr_i[1:0] != 2'b00);
   assign out_of_range = |imem_addr_i[31:2+AW];
   assign fault_d      = misaligned || out_of_range;
   assign data_d       = fault_d ? NOP : mem_q[imem_addr_i[2+:AW]];

   // A load never coincides with an accepted read, so no bypass is needed.
   always_ff @(posedge clk_i) begin
      if (load_v_i) begin
         mem_q[load_addr_i] <= load_data_i;
      end
   end

   // Stage 1 valid is the accept itself, so a fetch accepted together with a
   // flush survives as the redirected fetch. Later stages only move payload
   // when a live entry advances, which keeps the last stage (and therefore the
   // outputs) holding the most recent response during idle cycles.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < LATENCY; k++) begin
            v_q[k]     <= 1'b0;
            fault_q[k] <= 1'b0;
            data_q[k]  <= NOP;
         end
      end else begin
         v_q[0] <= accept;
         if (accept) begin
            fault_q[0] <= fault_d;
            data_q[0]  <= data_d;
         end
         for (int k = 1; k < LATENCY; k++) begin
            v_q[k] <= v_q[k-1] && !imem_flush_i;
            if (v_q[k-1] && !imem_flush_i) begin
               fault_q[k] <= fault_q[k-1];
               data_q[k]  <= data_q[k-1];
            end
         end
      end
   end

   assign imem_data_v_o = v_q[LATENCY-1];
   assign imem_fault_o  = fault_q[LATENCY-1];
   assign imem_data_o   = data_q[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

   localparam int          DEPTH = 64;
   localparam int          AW    = 6;
   localparam int          NDUT  = 3;
   localparam int          LATS [NDUT] = '{1, 2, 4};
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int          due;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          req_v;
   logic [31:0]   addr;
   logic          flush;
   logic          load_v;
   logic [AW-1:0] load_addr;
   logic [31:0]   load_data;

   logic          rdy [NDUT];
   logic          dv  [NDUT];
   logic          df  [NDUT];
   logic [31:0]   dd  [NDUT];

   exp_t          q [NDUT][$];
   logic [31:0]   mem_m [DEPTH];
   int            edge_n;
   int            checks;
   int            errors;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
         .clk_i         (clk),
         .rst_i         (rst_n),
         .imem_req_v_i  (req_v),
         .imem_addr_i   (addr),
         .imem_ready_o  (rdy[g]),
         .imem_flush_i  (flush),
         .imem_data_o   (dd[g]),
         .imem_data_v_o (dv[g]),
         .imem_fault_o  (df[g]),
         .load_v_i      (load_v),
         .load_addr_i   (load_addr),
         .load_data_i   (load_data)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut_lat%0d @edge %0d: got %h expected %h", nm, LATS[g], edge_n, act, exp);
      end
   endtask

   // Reference model: the accept rule, fault rule and memory contents give the
   // response; its due edge is the accept edge plus LATENCY-1.
   always @(posedge clk or negedge rst_n) begin
      exp_t        e;
      logic        acc;
      logic [29:0] wi;
      if (!rst_n) begin
         for (int g = 0; g < NDUT; g++) q[g].delete();
      end else begin
         edge_n++;
         acc = req_v && !load_v;
         if (flush) for (int g = 0; g < NDUT; g++) q[g].delete();
         if (acc) begin
            wi      = addr[31:2];
            e.fault = (addr[1:0] != 2'b00) || (wi >= DEPTH);
            e.data  = e.fault ? NOP : mem_m[wi[AW-1:0]];
            for (int g = 0; g < NDUT; g++) begin
               e.due = edge_n + LATS[g] - 1;
               q[g].push_back(e);
            end
         end
         if (load_v) mem_m[load_addr] = load_data;
      end
   end

   // Monitor: every cycle, each DUT must present exactly the response due now.
   always @(negedge clk) begin
      exp_t e;
      logic ev;
      for (int g = 0; g < NDUT; g++) begin
         chk("ready", g, {31'd0, rdy[g]}, {31'd0, !load_v});
         while (q[g].size() > 0 && q[g][0].due < edge_n) begin
            e = q[g].pop_front();
            checks++;
            errors++;
            $display("FAIL missing_resp dut_lat%0d: response due @edge %0d never seen (data %h)", LATS[g], e.due, e.data);
         end
         ev = (q[g].size() > 0) && (q[g][0].due == edge_n);
         chk("valid", g, {31'd0, dv[g]}, {31'd0, ev});
         if (ev) begin
            e = q[g].pop_front();
            chk("data", g, dd[g], e.data);
            chk("fault", g, {31'd0, df[g]}, {31'd0, e.fault});
         end
      end
   end

   task automatic drive(input logic rq, input logic [31:0] a, input logic fl,
                        input logic ld, input logic [AW-1:0] la, input logic [31:0] lw);
      req_v = rq; addr = a; flush = fl; load_v = ld; load_addr = la; load_data = lw;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
   endtask

   task automatic chk_reset_outputs(input string nm);
      for (int g = 0; g < NDUT; g++) begin
         chk({nm, "_v"}, g, {31'd0, dv[g]}, 32'd0);
         chk({nm, "_fault"}, g, {31'd0, df[g]}, 32'd0);
         chk({nm, "_data"}, g, dd[g], NOP);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int          sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      a   = {24'd0, 2'b00, 6'($urandom_range(0, DEPTH - 1))} << 2;
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      else if (sel == 1) a = $urandom | 32'h0000_1000;
      return a;
   endfunction

   initial begin
      checks = 0; errors = 0; edge_n = 0;
      req_v = 0; addr = 0; flush = 0; load_v = 0; load_addr = '0; load_data = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Fill the whole array so every readable word is defined.
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'd0, 1'b0, 1'b1, AW'(i), $urandom);

      // Load and in-order read
      drive(0, 0, 0, 1, 0, 32'h1111_1111);
      drive(0, 0, 0, 1, 1, 32'h2222_2222);
      drive(0, 0, 0, 1, 2, 32'h3333_3333);
      drive(0, 0, 0, 1, 3, 32'h4444_4444);
      for (int i = 0; i < 4; i++) drive(1, 32'(i * 4), 0, 0, 0, 0);
      idle(6);

      // Misaligned and out-of-range
      drive(1, 32'h6, 0, 0, 0, 0);
      drive(1, 32'(4 * DEPTH), 0, 0, 0, 0);
      idle(6);

      // Flush with redirect
      drive(1, 32'h0, 0, 0, 0, 0);
      drive(1, 32'h4, 0, 0, 0, 0);
      drive(1, 32'h8, 0, 0, 0, 0);
      drive(1, 32'hC, 1, 0, 0, 0);
      idle(6);

      // Load blocks request, then the held request sees the new word
      drive(1, 32'h0, 0, 1, 0, 32'hDEAD_BEEF);
      drive(1, 32'h0, 0, 1, 0, 32'hDEAD_BEEF);
      drive(1, 32'h0, 0, 0, 0, 0);
      idle(6);

      // Flush together with a blocked request and a load
      drive(1, 32'h8, 0, 0, 0, 0);
      drive(1, 32'h4, 1, 1, 5, 32'h5555_AAAA);
      drive(1, 32'h14, 0, 0, 0, 0);
      idle(6);

      // Reset mid-flight
      drive(1, 32'h8, 0, 0, 0, 0);
      drive(1, 32'h6, 0, 0, 0, 0);
      req_v = 0;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      #2 rst_n = 1'b1;
      idle(3);
      drive(1, 32'h4, 0, 0, 0, 0);
      idle(6);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) < 2, AW'($urandom), $urandom);
      end
      idle(8);

      for (int g = 0; g < NDUT; g++) chk("drain", g, 32'(q[g].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
